// File: rtl/mpsoc_ram_arb_pkg.sv
// Shared types and helpers for the 1R1W RAM arbiter.
//   state_t    : arbiter FSM states (INIT only reachable with MPSOC_RAM_INIT_EN)
//   be_bits    : byte-enable width for a given data width, (DBITS+7)/8
//   onehot2bin : index of the set bit in a one-hot vector of up to 8 bits
package mpsoc_ram_arb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_DBITS  = 32;
  localparam int DEF_BEBITS = (DEF_DBITS + 7) / 8;

  function automatic int be_bits(input int dbits);
    return (dbits + 7) / 8;
  endfunction

  function automatic logic [2:0] onehot2bin(input logic [7:0] oh);
    logic [2:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) b = b | 3'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/mpsoc_rr_arbiter.sv
// Round-robin arbiter with combinational one-hot grant.
//   clk   : clock
//   rst_n : synchronous active-low reset (pointer -> 0)
//   en    : arbitration enable; no grant and no pointer update when low
//   req   : per-requester request
//   gnt   : one-hot grant, first requester found scanning from ptr upward
//   ptr   : current highest-priority requester
module mpsoc_rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [NREQ-1:0]           req,
  output logic [NREQ-1:0]           gnt,
  output logic [$clog2(NREQ)-1:0]   ptr
);

  localparam int PW = $clog2(NREQ);

  logic          found;
  logic [PW-1:0] ptr_nxt;
  int            idx;
  int            win;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    win   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
        win      = idx;
      end
    end
    // The winner drops to lowest priority next cycle.
    ptr_nxt = PW'((win + 1) % NREQ);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/mpsoc_ram_1r1w_arbiter.sv
// Shares one 1R1W RAM among NREQ requesters with independent round-robin
// arbitration on the write and read ports. Grants are combinational; read
// data returns one cycle after grant, tagged by the one-hot rvalid_o.
// Optional macro MPSOC_RAM_INIT_EN: after reset, fill every RAM word with
// INIT_VALUE before accepting traffic.
// Ports:
//   clk_i, rst_ni               : clock, synchronous active-low reset
//   wreq_i/waddr_i/wdata_i/wbe_i: packed per-requester write requests
//   wgnt_o                      : one-hot write grant
//   rreq_i/raddr_i              : packed per-requester read requests
//   rgnt_o, rvalid_o, rdata_o   : read grant, response valid, shared data
//   ram_*                       : RAM write/read port (1-cycle read latency)
//   init_done_o                 : high while accepting traffic
module mpsoc_ram_1r1w_arbiter
  import mpsoc_ram_arb_pkg::*;
#(
  parameter int               NREQ       = 4,
  parameter int               ABITS      = 10,
  parameter int               DBITS      = 32,
  parameter logic [DBITS-1:0] INIT_VALUE = '0
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NREQ-1:0]                 wreq_i,
  input  logic [NREQ*ABITS-1:0]           waddr_i,
  input  logic [NREQ*DBITS-1:0]           wdata_i,
  input  logic [NREQ*((DBITS+7)/8)-1:0]   wbe_i,
  output logic [NREQ-1:0]                 wgnt_o,
  input  logic [NREQ-1:0]                 rreq_i,
  input  logic [NREQ*ABITS-1:0]           raddr_i,
  output logic [NREQ-1:0]                 rgnt_o,
  output logic [NREQ-1:0]                 rvalid_o,
  output logic [DBITS-1:0]                rdata_o,
  output logic [ABITS-1:0]                ram_waddr_o,
  output logic [DBITS-1:0]                ram_din_o,
  output logic                            ram_we_o,
  output logic [(DBITS+7)/8-1:0]          ram_be_o,
  output logic [ABITS-1:0]                ram_raddr_o,
  output logic                            ram_re_o,
  input  logic [DBITS-1:0]                ram_dout_i,
  output logic                            init_done_o
);

  localparam int BEBITS = be_bits(DBITS);
  localparam int PW     = $clog2(NREQ);

  state_t        state;
  state_t        state_nxt;
  logic          run;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wsel;
  logic [PW-1:0] rsel;

`ifdef MPSOC_RAM_INIT_EN
  logic [ABITS-1:0] init_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      init_cnt <= '0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + 1'b1;
    end
  end
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
`ifdef MPSOC_RAM_INIT_EN
      state <= INIT;
`else
      state <= RUN;
`endif
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: INIT leaves after the last address is written
  always_comb begin
    state_nxt = state;
    case (state)
`ifdef MPSOC_RAM_INIT_EN
      INIT:    state_nxt = (&init_cnt) ? RUN : INIT;
`else
      INIT:    state_nxt = RUN;
`endif
      RUN:     state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Gating with rst_ni keeps every grant and RAM strobe low during reset.
  assign run         = rst_ni && (state == RUN);
  assign init_done_o = run;

  mpsoc_rr_arbiter #(.NREQ(NREQ)) u_warb (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .en    (run),
    .req   (wreq_i),
    .gnt   (wgnt_o),
    .ptr   (wptr)
  );

  mpsoc_rr_arbiter #(.NREQ(NREQ)) u_rarb (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .en    (run),
    .req   (rreq_i),
    .gnt   (rgnt_o),
    .ptr   (rptr)
  );

  // Without a grant the mux points at the pointer's requester (don't care).
  assign wsel = (|wgnt_o) ? PW'(onehot2bin(8'(wgnt_o))) : wptr;
  assign rsel = (|rgnt_o) ? PW'(onehot2bin(8'(rgnt_o))) : rptr;

  // Output logic: RAM port muxing
  always_comb begin
    ram_we_o    = |wgnt_o;
    ram_re_o    = |rgnt_o;
    ram_waddr_o = '0;
    ram_din_o   = '0;
    ram_be_o    = '0;
    ram_raddr_o = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (int'(wsel) == k) begin
        ram_waddr_o = waddr_i[k*ABITS +: ABITS];
        ram_din_o   = wdata_i[k*DBITS +: DBITS];
        ram_be_o    = wbe_i[k*BEBITS +: BEBITS];
      end
      if (int'(rsel) == k) begin
        ram_raddr_o = raddr_i[k*ABITS +: ABITS];
      end
    end
`ifdef MPSOC_RAM_INIT_EN
    if (state == INIT) begin
      ram_we_o    = rst_ni;
      ram_be_o    = '1;
      ram_din_o   = INIT_VALUE;
      ram_waddr_o = init_cnt;
    end
`endif
  end

  // Read response: valid is the grant delayed by the RAM latency
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_o <= '0;
    end else begin
      rvalid_o <= rgnt_o;
    end
  end

  assign rdata_o = ram_dout_i;

endmodule

// File: tb/tb_mpsoc_ram_1r1w_arbiter.sv
// Bench for mpsoc_ram_1r1w_arbiter with a write-first 1-cycle RAM model.
// Build with MPSOC_RAM_INIT_EN defined to exercise the init sequence.
module tb_mpsoc_ram_1r1w_arbiter;

  localparam int NREQ  = 4;
  localparam int DBITS = 32;
  localparam int BEB   = 4;
`ifdef MPSOC_RAM_INIT_EN
  localparam int               ABITS = 4;
  localparam logic [DBITS-1:0] INITV = 32'hA5A5A5A5;
`else
  localparam int               ABITS = 10;
  localparam logic [DBITS-1:0] INITV = 32'h0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NREQ-1:0]         wreq;
  logic [NREQ*ABITS-1:0]   waddr;
  logic [NREQ*DBITS-1:0]   wdata;
  logic [NREQ*BEB-1:0]     wbe;
  logic [NREQ-1:0]         wgnt;
  logic [NREQ-1:0]         rreq;
  logic [NREQ*ABITS-1:0]   raddr;
  logic [NREQ-1:0]         rgnt;
  logic [NREQ-1:0]         rvalid;
  logic [DBITS-1:0]        rdata;
  logic [ABITS-1:0]        ram_waddr;
  logic [DBITS-1:0]        ram_din;
  logic                    ram_we;
  logic [BEB-1:0]          ram_be;
  logic [ABITS-1:0]        ram_raddr;
  logic                    ram_re;
  logic [DBITS-1:0]        ram_dout;
  logic                    init_done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mpsoc_ram_1r1w_arbiter #(
    .NREQ(NREQ), .ABITS(ABITS), .DBITS(DBITS), .INIT_VALUE(INITV)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wreq_i(wreq), .waddr_i(waddr), .wdata_i(wdata), .wbe_i(wbe), .wgnt_o(wgnt),
    .rreq_i(rreq), .raddr_i(raddr), .rgnt_o(rgnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .ram_waddr_o(ram_waddr), .ram_din_o(ram_din), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_raddr_o(ram_raddr), .ram_re_o(ram_re), .ram_dout_i(ram_dout),
    .init_done_o(init_done)
  );

  // Write-first RAM model with 1-cycle read latency
  logic [DBITS-1:0] mem [0:(1<<ABITS)-1];
  logic [DBITS-1:0] rd_word;
  always @(posedge clk) begin
    rd_word = mem[ram_raddr];
    if (ram_we) begin
      for (int b = 0; b < BEB; b++) begin
        if (ram_be[b]) begin
          mem[ram_waddr][8*b +: 8] <= ram_din[8*b +: 8];
          if (ram_waddr == ram_raddr) rd_word[8*b +: 8] = ram_din[8*b +: 8];
        end
      end
    end
    if (ram_re) ram_dout <= rd_word;
  end

  typedef struct {
    logic            rst;
    logic [NREQ-1:0] wreq;
    logic [NREQ-1:0] rreq;
    logic [NREQ-1:0] wgnt;
    logic [NREQ-1:0] rgnt;
    logic [NREQ-1:0] rvld;
    logic            done;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < NREQ; i++) if (oh[i]) r = i;
    return r;
  endfunction

  initial begin
    rst_n = 1'b0;
    wreq  = '0;
    rreq  = '0;
    waddr = '0;
    raddr = '0;
    wdata = '0;
    wbe   = '1;
    for (int k = 0; k < NREQ; k++) begin
      waddr[k*ABITS +: ABITS] = ABITS'(32'h100 + k);
      raddr[k*ABITS +: ABITS] = ABITS'(32'h200 + k);
      wdata[k*DBITS +: DBITS] = 32'h1111_0000 + k;
    end
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("reset rvalid", 64'(rvalid), 64'h0);
    check("reset init_done", 64'(init_done), 64'h0);

`ifdef MPSOC_RAM_INIT_EN
    // Init fill: 16 forced writes, requests ignored
    for (int i = 0; i < (1 << ABITS); i++) begin
      next_cycle();
      rst_n = 1'b1;
      wreq  = '1;
      rreq  = '1;
      @(negedge clk);
      check($sformatf("init%0d we", i), 64'(ram_we), 64'h1);
      check($sformatf("init%0d waddr", i), 64'(ram_waddr), 64'(i));
      check($sformatf("init%0d din", i), 64'(ram_din), 64'(INITV));
      check($sformatf("init%0d be", i), 64'(ram_be), 64'hF);
      check($sformatf("init%0d wgnt", i), 64'(wgnt), 64'h0);
      check($sformatf("init%0d rgnt", i), 64'(rgnt), 64'h0);
      check($sformatf("init%0d re", i), 64'(ram_re), 64'h0);
      check($sformatf("init%0d done", i), 64'(init_done), 64'h0);
    end
    next_cycle();
    wreq = '0;
    rreq = 4'b0001;
    raddr[0 +: ABITS] = ABITS'(7);
    @(negedge clk);
    check("init done", 64'(init_done), 64'h1);
    check("post-init rgnt", 64'(rgnt), 64'h1);
    check("post-init raddr", 64'(ram_raddr), 64'h7);
    next_cycle();
    rreq = '0;
    @(negedge clk);
    check("post-init rvalid", 64'(rvalid), 64'h1);
    check("post-init rdata", 64'(rdata), 64'(INITV));
`else
    //            rst   wreq     rreq     wgnt     rgnt     rvld     done
    tbl[0]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{1'b1, 4'b0001, 4'b1111, 4'b0001, 4'b0001, 4'b0000, 1'b1};
    tbl[2]  = '{1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b0010, 4'b0001, 1'b1};
    tbl[3]  = '{1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b0100, 4'b0010, 1'b1};
    tbl[4]  = '{1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b1000, 4'b0100, 1'b1};
    tbl[5]  = '{1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b0001, 4'b1000, 1'b1};
    tbl[6]  = '{1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b0010, 4'b0001, 1'b1};
    tbl[7]  = '{1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b0100, 4'b0010, 1'b1};
    tbl[8]  = '{1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b1000, 4'b0100, 1'b1};
    tbl[9]  = '{1'b1, 4'b0101, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 1'b1};
    tbl[10] = '{1'b1, 4'b0101, 4'b0010, 4'b0001, 4'b0010, 4'b0000, 1'b1};
    tbl[11] = '{1'b1, 4'b1000, 4'b1010, 4'b1000, 4'b1000, 4'b0010, 1'b1};
    tbl[12] = '{1'b1, 4'b0000, 4'b1010, 4'b0000, 4'b0010, 4'b1000, 1'b1};
    tbl[13] = '{1'b1, 4'b0000, 4'b1010, 4'b0000, 4'b1000, 4'b0010, 1'b1};
    tbl[14] = '{1'b1, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b1000, 1'b1};
    tbl[15] = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1'b0};
    tbl[16] = '{1'b1, 4'b0010, 4'b1111, 4'b0010, 4'b0001, 4'b0000, 1'b1};

    for (int i = 0; i < 17; i++) begin
      next_cycle();
      rst_n = tbl[i].rst;
      wreq  = tbl[i].wreq;
      rreq  = tbl[i].rreq;
      @(negedge clk);
      check($sformatf("row%0d wgnt", i), 64'(wgnt), 64'(tbl[i].wgnt));
      check($sformatf("row%0d rgnt", i), 64'(rgnt), 64'(tbl[i].rgnt));
      check($sformatf("row%0d rvalid", i), 64'(rvalid), 64'(tbl[i].rvld));
      check($sformatf("row%0d done", i), 64'(init_done), 64'(tbl[i].done));
      check($sformatf("row%0d we", i), 64'(ram_we), 64'(|tbl[i].wgnt));
      check($sformatf("row%0d re", i), 64'(ram_re), 64'(|tbl[i].rgnt));
      if (|tbl[i].wgnt)
        check($sformatf("row%0d waddr", i), 64'(ram_waddr), 64'(32'h100 + oh_idx(tbl[i].wgnt)));
      if (|tbl[i].rgnt)
        check($sformatf("row%0d raddr", i), 64'(ram_raddr), 64'(32'h200 + oh_idx(tbl[i].rgnt)));
    end

    // Same-cycle write (req 2) and read (req 1) of 0x010: write-first data
    next_cycle();
    wreq = 4'b0100;
    rreq = 4'b0010;
    waddr[2*ABITS +: ABITS] = ABITS'(32'h010);
    wdata[2*DBITS +: DBITS] = 32'h12345678;
    raddr[1*ABITS +: ABITS] = ABITS'(32'h010);
    @(negedge clk);
    check("rw wgnt", 64'(wgnt), 64'h4);
    check("rw rgnt", 64'(rgnt), 64'h2);
    check("rw waddr", 64'(ram_waddr), 64'h010);
    check("rw din", 64'(ram_din), 64'h12345678);
    check("rw raddr", 64'(ram_raddr), 64'h010);
    next_cycle();
    wreq = 4'b0001;
    rreq = 4'b0000;
    waddr[0 +: ABITS] = ABITS'(32'h005);
    wdata[0 +: DBITS] = 32'hDEADBEEF;
    wbe[0 +: BEB]     = 4'hF;
    @(negedge clk);
    check("rw rvalid", 64'(rvalid), 64'h2);
    check("rw rdata", 64'(rdata), 64'h12345678);
    // Single write from requester 0
    check("w0 wgnt", 64'(wgnt), 64'h1);
    check("w0 we", 64'(ram_we), 64'h1);
    check("w0 waddr", 64'(ram_waddr), 64'h005);
    check("w0 din", 64'(ram_din), 64'hDEADBEEF);
    check("w0 be", 64'(ram_be), 64'hF);
    next_cycle();
    wreq = '0;
    @(negedge clk);
    check("idle we", 64'(ram_we), 64'h0);
    check("idle rvalid", 64'(rvalid), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mpsoc_ram_1r1w_arbiter.md
Name: mpsoc_ram_1r1w_arbiter

Overview:
- Shares one mpsoc_ram_1r1w instance among NREQ requesters, with an independent round-robin arbiter on each side:
  - write side → RAM write port;
  - read side → RAM read port.
- Grant is combinational. The read response returns one cycle after grant, tagged by a one-hot valid.
- Sits between core/DMA memory clients and the RAM block in the MPSoC memory subsystem.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ABITS, 10, RAM address width.
- DBITS, 32, RAM data width.
- INIT_VALUE, 0, DBITS-wide word written during init (only used with MPSOC_RAM_INIT_EN).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- wreq_i  in  NREQ  per-requester write request
- waddr_i  in  NREQ*ABITS  packed write addresses, requester k at [k*ABITS +: ABITS]
- wdata_i  in  NREQ*DBITS  packed write data
- wbe_i  in  NREQ*((DBITS+7)/8)  packed byte enables
- wgnt_o  out  NREQ  one-hot write grant
- rreq_i  in  NREQ  per-requester read request
- raddr_i  in  NREQ*ABITS  packed read addresses
- rgnt_o  out  NREQ  one-hot read grant
- rvalid_o  out  NREQ  one-hot read data valid
- rdata_o  out  DBITS  read data, shared by all requesters
- ram_waddr_o  out  ABITS  RAM write address
- ram_din_o  out  DBITS  RAM write data
- ram_we_o  out  1  RAM write enable
- ram_be_o  out  (DBITS+7)/8  RAM byte enables
- ram_raddr_o  out  ABITS  RAM read address
- ram_re_o  out  1  RAM read enable
- ram_dout_i  in  DBITS  RAM read data, 1-cycle latency
- init_done_o  out  1  arbiter accepting traffic

Behaviour:
- One clock. Reset is synchronous and active-low, sampled on the clk_i rising edge.
- Reset values:
  - wptr = rptr = 0;
  - rvalid_o = 0;
  - init_done_o = 0;
  - all grants and ram_we_o/ram_re_o = 0 while rst_ni = 0.
- FSM states:
  - INIT: only with macro.
  - RUN: normal arbitration.
  - Reset enters INIT if the macro is defined, else RUN. init_done_o = 1 exactly in RUN.
- Write arbitration (RUN):
  - Grant goes to the first requester with wreq_i set, scanning wptr, wptr+1, ... modulo NREQ.
  - wgnt_o is asserted in the same cycle as the request. A request is consumed when req and gnt are both high.
  - On grant to k: ram_we_o = 1, and ram_waddr_o/ram_din_o/ram_be_o = requester k's fields.
  - Next cycle wptr = (k+1) mod NREQ. The pointer is unchanged when there is no grant.
  - With no request: ram_we_o = 0; address/data hold the wptr requester's fields (don't care).
- Read arbitration: identical scheme with rptr, rreq_i, rgnt_o, ram_re_o, ram_raddr_o.
- Read response:
  - rvalid_o is rgnt_o registered (1-cycle latency).
  - rdata_o = ram_dout_i, passed straight through.
  - A requester may re-request on the cycle of its rvalid (full throughput: 1 read + 1 write per cycle).
- Same-cycle read and write to the same address: the arbiter adds no bypass. The RAM block returns the written data (write-first).
- Requests dropped before grant are legal. Grants never go to a requester without a request.
- Reset mid-operation: a pending rvalid is cleared and the pointers return to 0. No partial write is issued during the reset cycle.
- Single requester: granted every cycle it requests.

Optional Feature:
- MPSOC_RAM_INIT_EN defined:
  - INIT state walks a counter 0..2^ABITS-1, driving ram_we_o = 1, ram_be_o = all ones, ram_din_o = INIT_VALUE, ram_waddr_o = counter.
  - All wgnt_o/rgnt_o = 0 and ram_re_o = 0 during INIT.
  - After writing the last address (counter wrap), the next state is RUN.
  - init_done_o rises 2^ABITS cycles after reset deassertion.
- Undefined: no counter; the FSM resets straight into RUN, so init_done_o = 1 from the first cycle after reset release.

Decomposition:
- Package mpsoc_ram_arb_pkg holds:
  - typedef state_t {INIT, RUN};
  - function onehot2bin;
  - localparam BEBITS = (DBITS+7)/8 helper.
- One sub-module, instanced twice (write and read): mpsoc_rr_arbiter #(NREQ), holding the req → one-hot gnt logic, the pointer register, and an update enable.

Test Plan:
- Reset, macro undefined; wreq_i = 4'b0001, waddr0 = 0x005, wdata0 = 0xDEADBEEF → same cycle wgnt_o = 0001, ram_we_o = 1, ram_waddr_o = 0x005, ram_be_o = 4'hF.
- All four requesters hold rreq_i = 4'b1111 for 8 cycles → rgnt_o sequence 0001, 0010, 0100, 1000, repeating; rvalid_o equals the previous cycle's rgnt_o.
- Write 0x12345678 to 0x010 from requester 2 and read 0x010 from requester 1 in the same cycle → next cycle rvalid_o = 0010, rdata_o = 0x12345678.
- rreq_i = 4'b1010 with rptr = 2 → grant 1000, then 0010, then 1000; requesters 0 and 2 are never granted.
- MPSOC_RAM_INIT_EN with ABITS = 4 and INIT_VALUE = 0xA5A5A5A5:
  - after reset, 16 write cycles to addresses 0..15, then init_done_o = 1;
  - requests during INIT are not granted;
  - a read of 0x7 afterwards returns 0xA5A5A5A5.
- Assert rst_ni = 0 in the cycle after a read grant → rvalid_o = 0 in the following cycle; the pointer returns to 0 and the next grant goes to requester 0.
